// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART receive path.
// Holds the receiver state enum, byte width and mid-bit helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    localparam int DATA_BITS = 8;

    function automatic int mid_point(input int n);
        return n / 2;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: received-byte valid/ready bundle with error flags.
// master = receiver side, slave = consumer side.
interface uart_rx_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output data,
        output valid,
        output frame_err,
        output overrun,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  frame_err,
        input  overrun,
        output ready
    );

endinterface

// File: rtl/uart_sync.sv
// uart_sync: 2-flop synchroniser for an asynchronous input.
// RST_VAL sets both flops on reset (idle level of the line).
module uart_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver, mid-bit sampling, valid/ready out with flags.
// Define UART_RX_MAJORITY_EN for 2-of-3 voting around mid-bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int N_CYCLES = 16
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      rx,
    uart_rx_if.master bus
);

    localparam int CW  = $clog2(N_CYCLES);
    localparam int MID = mid_point(N_CYCLES);
    localparam logic [CW-1:0] LAST     = CW'(N_CYCLES - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [CW-1:0] SAMP_A = CW'(MID - 1);
    localparam logic [CW-1:0] SAMP_B = CW'(MID);
    localparam logic [CW-1:0] DECIDE = CW'(MID + 1);
`else
    localparam logic [CW-1:0] DECIDE = CW'(MID);
`endif

    logic                 rs;
    state_t               state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic [2:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 bit_val;
    logic                 sample;

    uart_sync #(.RST_VAL(1'b1)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (rx),
        .q     (rs)
    );

`ifdef UART_RX_MAJORITY_EN
    logic s0_q, s0_d;
    logic s1_q, s1_d;

    always_comb begin
        s0_d = s0_q;
        s1_d = s1_q;
        if (count_q == SAMP_A) s0_d = rs;
        if (count_q == SAMP_B) s1_d = rs;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s0_q <= 1'b1;
            s1_q <= 1'b1;
        end else begin
            s0_q <= s0_d;
            s1_q <= s1_d;
        end
    end

    assign bit_val = (s0_q & s1_q) | (s0_q & rs) | (s1_q & rs);
`else
    assign bit_val = rs;
`endif

    // count tracks the cycle offset within the current bit, 0 at the edge
    assign sample = (count_q == DECIDE);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q & ~bus.ready;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        if (state_q != IDLE && state_q != BREAK) begin
            count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
        end
        unique case (state_q)
            IDLE: begin
                count_d = '0;
                if (!rs) begin
                    state_d = START;
                    count_d = CW'(1);
                end
            end
            START: begin
                if (sample) begin
                    if (bit_val) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        idx_d   = '0;
                    end
                end
            end
            DATA: begin
                if (sample) begin
                    shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == LAST_BIT) state_d = STOP;
                end
            end
            STOP: begin
                if (sample) begin
                    if (bit_val) begin
                        // back to IDLE mid-stop so a zero-gap next start is caught
                        state_d = IDLE;
                        if (valid_q && !bus.ready) begin
                            ovr_d = 1'b1;
                        end else begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end
                    end else begin
                        state_d = BREAK;
                        ferr_d  = 1'b1;
                    end
                end
            end
            BREAK: begin
                count_d = '0;
                if (rs) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.overrun   = ovr_q;

endmodule
